// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes,
// funct codes, ALU operations and datapath mux selects.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_R_EX     = 4'd6,
      S_R_WB     = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_I_EX     = 4'd10,
      S_I_WB     = 4'd11,
      S_HALT     = 4'd15
   } state_e;

   // What the ALU is doing in the current state; resolved to alu_ctrl by mips_alu_decode.
   typedef enum logic [2:0] {
      CLS_NONE,
      CLS_ADD,
      CLS_SUB,
      CLS_R,
      CLS_I
   } alu_class_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // States whose exit completes an instruction.
   function automatic logic is_retire_state(input state_e s);
      return (s == S_MEM_WB) || (s == S_MEM_WR) || (s == S_R_WB) ||
             (s == S_BRANCH) || (s == S_JUMP)   || (s == S_I_WB);
   endfunction

endpackage

// File: rtl/mips_alu_decode.sv
// Combinational ALU operation decode from state class, opcode and funct.
module mips_alu_decode
   import mips_ctrl_pkg::*;
(
   input  alu_class_e  alu_class,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   output logic [2:0]  alu_ctrl,
   output logic        funct_illegal
);

   always_comb begin
      alu_ctrl      = ALU_AND;
      funct_illegal = 1'b0;
      case (alu_class)
         CLS_ADD: alu_ctrl = ALU_ADD;
         CLS_SUB: alu_ctrl = ALU_SUB;
         CLS_R: begin
            case (funct)
               FN_ADD:  alu_ctrl = ALU_ADD;
               FN_SUB:  alu_ctrl = ALU_SUB;
               FN_AND:  alu_ctrl = ALU_AND;
               FN_OR:   alu_ctrl = ALU_OR;
               FN_SLT:  alu_ctrl = ALU_SLT;
               default: funct_illegal = 1'b1;
            endcase
         end
         CLS_I: begin
            case (opcode)
               OP_ADDI: alu_ctrl = ALU_ADD;
               OP_ANDI: alu_ctrl = ALU_AND;
               OP_ORI:  alu_ctrl = ALU_OR;
               OP_SLTI: alu_ctrl = ALU_SLT;
               default: alu_ctrl = ALU_AND;
            endcase
         end
         default: alu_ctrl = ALU_AND;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the multi-cycle MIPS datapath with retired-instruction counter.
// Optional macro MIPS_CTRL_BNE_EN adds bne decoding through the BRANCH state.
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter bit HALT_ON_ILLEGAL = 1'b1,
   parameter int CNT_W           = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   output logic             pc_en,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_ctrl,
   output logic [1:0]       pc_source,
   output logic [3:0]       state,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   state_e     cur, nxt;
   alu_class_e alu_class;
   logic       funct_illegal;
   logic       pc_write, pc_write_cond, branch_taken;
   state_e     illegal_dest;

   assign illegal_dest = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
   assign state        = cur;

   mips_alu_decode u_alu_decode (
      .alu_class     (alu_class),
      .opcode        (opcode),
      .funct         (funct),
      .alu_ctrl      (alu_ctrl),
      .funct_illegal (funct_illegal)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) cur <= S_FETCH;
      else       cur <= nxt;
   end

   always_comb begin
      nxt = cur;
      case (cur)
         S_FETCH:  nxt = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW:                      nxt = S_MEM_ADDR;
               OP_RTYPE:                          nxt = S_R_EX;
               OP_BEQ:                            nxt = S_BRANCH;
`ifdef MIPS_CTRL_BNE_EN
               OP_BNE:                            nxt = S_BRANCH;
`endif
               OP_J:                              nxt = S_JUMP;
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nxt = S_I_EX;
               default:                           nxt = illegal_dest;
            endcase
         end
         S_MEM_ADDR: nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   nxt = S_MEM_WB;
         S_R_EX:     nxt = funct_illegal ? illegal_dest : S_R_WB;
         S_I_EX:     nxt = S_I_WB;
         S_HALT:     nxt = S_HALT;
         default:    nxt = S_FETCH;
      endcase
   end

`ifdef MIPS_CTRL_BNE_EN
   assign branch_taken = (opcode == OP_BNE) ? ~zero : zero;
`else
   assign branch_taken = zero;
`endif

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_B;
      pc_source     = PCSRC_ALU;
      alu_class     = CLS_NONE;
      illegal       = 1'b0;
      case (cur)
         S_FETCH: begin
            mem_read  = 1'b1;
            ir_write  = 1'b1;
            alu_src_b = SRCB_FOUR;
            alu_class = CLS_ADD;
            pc_write  = 1'b1;
         end
         S_DECODE: begin
            alu_src_b = SRCB_IMM_SH;
            alu_class = CLS_ADD;
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_class = CLS_ADD;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         S_R_EX: begin
            alu_src_a = 1'b1;
            alu_class = CLS_R;
         end
         S_R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_class     = CLS_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_JUMP;
         end
         S_I_EX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_class = CLS_I;
         end
         S_I_WB:  reg_write = 1'b1;
         S_HALT:  illegal   = 1'b1;
         default: ;
      endcase
   end

   assign pc_en = pc_write | (pc_write_cond & branch_taken);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)                     retired <= '0;
      else if (is_retire_state(cur)) retired <= retired + CNT_W'(1);
   end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multi-cycle control unit for the team's MIPS datapath (`mips` top).
- Moore FSM sequences fetch/decode/execute/memory/writeback over the shared ALU, single unified memory and register file, one step per `clock`.
- Decodes opcode/funct from the instruction register and drives every datapath enable and mux select.
- Also counts retired instructions and flags illegal opcodes.

Parameters:
- HALT_ON_ILLEGAL, 1, 1 = enter HALT on unknown opcode/funct; 0 = treat as NOP and return to FETCH.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces FETCH, clears counter.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag, combinational from datapath.
- pc_en  out  1  PC load = pc_write | (pc_write_cond & branch_taken).
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- alu_ctrl  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  out  4  current state encoding, for debug.
- illegal  out  1  high while in HALT.
- retired  out  CNT_W  instructions completed since reset.

Behaviour:
- States, 4-bit encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EX=6, R_WB=7, BRANCH=8, JUMP=9, I_EX=10, I_WB=11, HALT=15.
- Async reset:
  - state=FETCH, retired=0.
  - All outputs take their FETCH-decoded values.
  - Reset mid-instruction abandons it; no partial register write occurs, since reg_write is only asserted in writeback states.
- Outputs are pure functions of state, plus opcode/funct/zero where noted. Unlisted outputs are 0 in each state.
- FETCH:
  - Drives mem_read, ir_write, alu_src_a=0, alu_src_b=01, alu_ctrl=ADD, pc_source=00, pc_write.
  - Next state: DECODE.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_ctrl=ADD (branch target precompute).
  - Transitions on opcode:
    - 100011 (lw) or 101011 (sw) -> MEM_ADDR.
    - 000000 (R-type) -> R_EX.
    - 000100 (beq) -> BRANCH.
    - 000010 (j) -> JUMP.
    - 001000 (addi), 001100 (andi), 001101 (ori), 001010 (slti) -> I_EX.
    - Anything else -> HALT if HALT_ON_ILLEGAL, else FETCH.
- MEM_ADDR:
  - Drives alu_src_a=1, alu_src_b=10, ADD.
  - Next state: MEM_RD for lw, MEM_WR for sw.
- MEM_RD: drives mem_read, i_or_d=1; next state MEM_WB.
- MEM_WB: drives reg_write, mem_to_reg=1, reg_dst=0; next state FETCH.
- MEM_WR: drives mem_write, i_or_d=1; next state FETCH.
- R_EX:
  - Drives alu_src_a=1, alu_src_b=00.
  - alu_ctrl from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
  - Unknown funct -> HALT or FETCH per HALT_ON_ILLEGAL. The counter is not incremented.
- R_WB: drives reg_write, reg_dst=1, mem_to_reg=0; next state FETCH.
- BRANCH:
  - Drives alu_src_a=1, alu_src_b=00, SUB, pc_write_cond, pc_source=01.
  - branch_taken = zero.
  - Next state: FETCH.
- JUMP: drives pc_write, pc_source=10; next state FETCH.
- I_EX:
  - Drives alu_src_a=1, alu_src_b=10.
  - alu_ctrl: addi ADD, andi AND, ori OR, slti SLT.
  - Next state: I_WB.
- I_WB: drives reg_write, reg_dst=0, mem_to_reg=0; next state FETCH.
- HALT: illegal=1, all enables 0, stays in HALT until reset.
- Latencies in cycles: lw 5, sw 4, R-type 4, I-type 4, beq 3, j 3.
- Counter:
  - retired increments by 1 on the clock edge leaving MEM_WB, MEM_WR, R_WB, BRANCH, JUMP or I_WB.
  - Wraps modulo 2^CNT_W silently.

Optional Feature:
- Macro: MIPS_CTRL_BNE_EN.
- Defined:
  - opcode 000101 (bne) decodes to BRANCH.
  - Inside BRANCH, branch_taken = ~zero for bne and zero for beq, selected by opcode.
- Undefined: 000101 is illegal.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum/localparams;
  - opcode and funct constants;
  - alu_ctrl codes;
  - alu_src_b / pc_source select codes.
- One sub-module, mips_alu_decode: combinational (state class, opcode, funct) -> alu_ctrl and a funct_illegal flag.
- FSM and counter stay in the top.

Test Plan:
- Reset release -> state=0, pc_en=1, mem_read=1, ir_write=1, retired=0 in first cycle.
- lw (opcode 100011) -> states 0,1,2,3,4,0.
  - reg_write=1 with mem_to_reg=1 only in state 4.
  - retired=1 after.
- add, then sub (funct 100000, 100010) -> alu_ctrl=010 then 110 in R_EX; reg_dst=1 in R_WB; retired=2.
- beq:
  - zero=1 -> pc_en=1 in BRANCH.
  - zero=0 -> pc_en=0.
  - Both take 3 cycles.
- opcode 111111 with HALT_ON_ILLEGAL=1 -> HALT, illegal=1 held 10 cycles, retired unchanged.
  - Async reset mid-HALT -> FETCH immediately, before the next clock edge.
- With MIPS_CTRL_BNE_EN: bne with zero=0 -> pc_en=1.
  - Without the macro: bne -> HALT.
